state_add3_sequencer: RTL
=========================

# state_add3_sequencer

Sequencer that drives one polynomial state-add pass, oState = a + b + c, over a full Kyber polynomial: 256 coefficients at 8 lanes per beat, so 32 beats. On a start pulse it walks a shared read address over three 1-cycle-latency source memories. It performs the signed 3-operand lane add and presents each result beat on a valid/ready output port with a 2-entry buffer for backpressure. It sits between the masked-decode buffers (b, c) and the polynomial RAM (a) in the decryption datapath, and signals completion to the top-level FSM.

## Interface
- NUM_BEATS, 32, beats per pass (256 coeffs / 8 lanes)
- ADDR_W, 5, read/write beat address width; must satisfy 2^ADDR_W >= NUM_BEATS
- A_W, 128, a-operand width (8 lanes x 16 bit)
- B_W, 32, b-operand width (8 lanes x 4 bit)
- C_W, 96, c-operand width (8 lanes x 12 bit)
- O_W, 128, result width (8 lanes x 16 bit)

Ports (one clock; reset is synchronous and active-low):
- iClk  in  1  clock, all logic on rising edge
- iRst_n  in  1  synchronous active-low reset
- iStart  in  1  start pulse, honoured only in IDLE
- oBusy  out  1  high in RUN and DRAIN
- oDone  out  1  one-cycle pulse after the last beat is accepted
- oRd_en  out  1  read strobe to all three sources
- oRd_addr  out  ADDR_W  beat address to all three sources
- iCoeffs_a  in  A_W  a data, valid the cycle after oRd_en
- iCoeffs_b  in  B_W  b data, valid the cycle after oRd_en
- iCoeffs_c  in  C_W  c data, valid the cycle after oRd_en
- oOut_valid  out  1  result beat valid
- iOut_ready  in  1  sink accepts when high with oOut_valid
- oOut_data  out  O_W  result beat
- oOut_addr  out  ADDR_W  beat index of oOut_data

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on iStart.
  - RUN -> DRAIN after the read with address NUM_BEATS-1 is issued.
  - DRAIN -> DONE when the last beat is accepted (oOut_valid & iOut_ready on beat NUM_BEATS-1).
  - DONE -> IDLE unconditionally; oDone is high only in DONE.
- iStart outside IDLE is ignored. No queuing.
- Read issue, RUN only:
  - oRd_en = 1 when (fifo_count + inflight − pop) < 2, where pop = oOut_valid & iOut_ready.
  - inflight is 1 if oRd_en was high in the previous cycle.
  - oRd_addr increments by 1 after each issued read, from 0 to NUM_BEATS-1. It never wraps within a pass and is cleared to 0 on entering IDLE.
- Data capture: in the cycle after oRd_en, compute the sum and push it into the 2-entry FIFO, tagged with the registered issued address.
- Lane arithmetic, k = 0..7:
  - a lane k = iCoeffs_a[16k+15 : 16k]
  - b lane k = iCoeffs_b[31−4k −: 4] (lane 0 at MSBs)
  - c lane k = iCoeffs_c[95−12k −: 12] (lane 0 at MSBs)
  - All three operands are sign-extended to 16 bit, summed modulo 2^16, and written to oOut_data[16k+15 : 16k].
  - No reduction mod q, no saturation.
- FIFO output: oOut_data and oOut_addr are the FIFO head. They stay stable while oOut_valid & !iOut_ready. Beats leave in address order.
- Reset (iRst_n low at a clock edge), in any state:
  - FSM -> IDLE; FIFO and inflight flag cleared; any partial pass is discarded.
  - All outputs 0: oBusy, oDone, oRd_en, oRd_addr, oOut_valid, oOut_data, oOut_addr.

## Timing
- Cycle 0: iStart sampled in IDLE.
- Cycle 1: RUN, oBusy = 1, oRd_en = 1, oRd_addr = 0.
- Cycle 2: source data valid; sum pushed into the FIFO.
- Cycle 3: oOut_valid = 1, oOut_addr = 0.
- Start-to-first-valid latency is 3 cycles. With iOut_ready held high, throughput is 1 beat/cycle.
- With iOut_ready = 1 throughout:
  - last read in cycle NUM_BEATS
  - last beat valid and accepted in cycle NUM_BEATS+2
  - oDone high in cycle NUM_BEATS+3, oBusy low from that cycle
  - IDLE in cycle NUM_BEATS+4
- Backpressure: at most 2 beats are buffered. oRd_en drops within the cycle the credit condition fails, so no beat is ever dropped or overwritten.
- Simultaneous push and pop with fifo_count = 2 cannot occur; the credit rule prevents it.

## Test plan
- Full pass, iOut_ready = 1, a beat n = all lanes n, b = c = 0:
  - 32 beats with oOut_addr 0..31, lanes equal to n
  - first oOut_valid in cycle 3
  - oDone a single pulse in cycle 35
- Lane mapping and sign on beat 0:
  - a = 0x0005 in every lane, b = 0xF0000000, c = 0x800 in bits [95:84], all other bits 0
  - lane 0 = 0xF804; lanes 1..7 = 0x0005
- Backpressure: drop iOut_ready for 10 cycles starting at cycle 8:
  - oRd_en goes low, and at most 2 beats are pending
  - oOut_data holds stable while stalled
  - after release all 32 beats arrive in order with correct values
  - oDone is delayed by exactly 10 cycles
- iStart pulsed in cycles 5 and 20 during a pass: no restart, oRd_addr sequence unaffected, exactly one oDone.
- iRst_n low for 1 cycle at cycle 15:
  - all outputs 0 the next cycle, FSM in IDLE
  - a new iStart then runs a clean pass from address 0
- Randomized iOut_ready (50%) over 20 passes:
  - scoreboard matches all beats against the reference lane sum
  - no loss or duplication
  - exactly one oDone per pass

Source files
------------

// File: rtl/state_add3_sequencer.sv
// state_add3_sequencer: streams the lane sum a + b + c over one polynomial pass through a 2-deep output buffer
module state_add3_sequencer #(
  parameter int NUM_BEATS = 32,
  parameter int ADDR_W = 5,
  parameter int A_W = 128,
  parameter int B_W = 32,
  parameter int C_W = 96,
  parameter int O_W = 128
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  output logic              oBusy,
  output logic              oDone,
  output logic              oRd_en,
  output logic [ADDR_W-1:0] oRd_addr,
  input  logic [A_W-1:0]    iCoeffs_a,
  input  logic [B_W-1:0]    iCoeffs_b,
  input  logic [C_W-1:0]    iCoeffs_c,
  output logic              oOut_valid,
  input  logic              iOut_ready,
  output logic [O_W-1:0]    oOut_data,
  output logic [ADDR_W-1:0] oOut_addr
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BEATS - 1);
  state_t state, stateNext;
  logic inflight, wrPtr, rdPtr, pop, lastRead, lastPop;
  logic [1:0] count;
  logic [ADDR_W-1:0] issuedAddr;
  logic [O_W-1:0] sum;
  logic [O_W-1:0] memData [2];
  logic [ADDR_W-1:0] memAddr [2];
  assign oOut_valid = count != 2'd0;
  assign oOut_data = memData[rdPtr];
  assign oOut_addr = memAddr[rdPtr];
  assign pop = oOut_valid & iOut_ready;
  // A read is only issued when its result is guaranteed a free buffer slot.
  assign oRd_en = state == RUN && ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  assign lastRead = oRd_en && oRd_addr == LAST;
  assign lastPop = pop && oOut_addr == LAST;
  always_comb begin
    stateNext = state;
    oBusy = 1'b0;
    oDone = 1'b0;
    stateNext = state == IDLE  ? (iStart ? RUN : IDLE) :
                state == RUN   ? (lastRead ? DRAIN : RUN) :
                state == DRAIN ? (lastPop ? DONE : DRAIN) : IDLE;
    oBusy = state == RUN || state == DRAIN;
    oDone = state == DONE;
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < 8; k++)
      sum[16*k +: 16] = iCoeffs_a[16*k +: 16]
                      + {{12{iCoeffs_b[B_W-1-4*k]}}, iCoeffs_b[B_W-1-4*k -: 4]}
                      + {{4{iCoeffs_c[C_W-1-12*k]}}, iCoeffs_c[C_W-1-12*k -: 12]};
  end
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state <= IDLE;
      oRd_addr <= '0;
      inflight <= 1'b0;
      issuedAddr <= '0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
      memData <= '{default: '0};
      memAddr <= '{default: '0};
    end else begin
      state <= stateNext;
      oRd_addr <= stateNext == IDLE ? '0 : (oRd_en && !lastRead) ? oRd_addr + ADDR_W'(1) : oRd_addr;
      inflight <= oRd_en;
      if (oRd_en) issuedAddr <= oRd_addr;
      if (inflight) begin
        memData[wrPtr] <= sum;
        memAddr[wrPtr] <= issuedAddr;
        wrPtr <= !wrPtr;
      end
      if (pop) rdPtr <= !rdPtr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule
